rx_serial_param: RTL

RX_SERIAL_PARAM -- requirements
Module: rx_serial_param

---
 rtl/rx_serial_param.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_serial_param.sv
// rx_serial_param -- parameterised asynchronous serial receiver.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Each received word is stored with its parity and
// framing error flags in a receive FIFO drained through a valid/accept
// handshake.
// Build option: define RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; without it
// the FIFO is a single holding register.
module rx_serial_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV        = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] dados,
  output logic                 valido,
  input  logic                 aceito,
  output logic                 erro_paridade,
  output logic                 erro_quadro,
  output logic                 overrun,
  output logic [3:0]           db_estado
);

  localparam int CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BIT_W  = 4;
  localparam int WORD_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Elaboration-time parameter range checks
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("rx_serial_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("rx_serial_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("rx_serial_param: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("rx_serial_param: DIV must be at least 2");
  end
  if (!(FIFO_DEPTH == 2 || FIFO_DEPTH == 4 || FIFO_DEPTH == 8 || FIFO_DEPTH == 16)) begin : g_bad_depth
    $error("rx_serial_param: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    START    = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    STOP     = 4'd4,
    ARMAZENA = 4'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 fall, sample;
  logic [CNT_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 push_req, push, pop, drop, full, not_empty;
  logic [WORD_W-1:0]    word, head;

  // Odd parity: data plus parity bit must hold an odd number of ones;
  // even parity: an even number.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    case (PARITY)
      1:       return ~x;
      2:       return x;
      default: return 1'b0;
    endcase
  endfunction

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall   = rx_prev & ~rx_s2;
  assign sample = (tick_cnt == SAMPLE_PT);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:  if (fall) state_d = START;
      START:    if (sample) state_d = rx_s2 ? INICIAL : DADOS;
      DADOS:    if (sample && bit_cnt == DATA_LAST)
                  state_d = (PARITY != 0) ? PARIDADE : STOP;
      PARIDADE: if (sample) state_d = STOP;
      STOP:     if (sample && bit_cnt == STOP_LAST) state_d = ARMAZENA;
      ARMAZENA: state_d = INICIAL;
      default:  state_d = INICIAL;
    endcase
  end

  // FSM outputs: state code for debug and the one-cycle store request
  always_comb begin
    db_estado = state_q;
    push_req  = (state_q == ARMAZENA);
  end

  // Bit-tick and bit counters; the tick counter is held at zero while idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state_q == INICIAL || tick_cnt == CNT_LAST) tick_cnt <= '0;
      else                                            tick_cnt <= tick_cnt + 1'b1;
      if (state_q != state_d)
        bit_cnt <= '0;
      else if (sample && (state_q == DADOS || state_q == STOP))
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Data shift register, LSB arrives first so it enters at the top
  always_ff @(posedge clock) begin
    if (state_q == DADOS && sample) shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
  end

  // Per-frame error flags, cleared when a new frame starts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perr <= 1'b0;
      ferr <= 1'b0;
    end else if (state_q == INICIAL && fall) begin
      perr <= 1'b0;
      ferr <= 1'b0;
    end else if (sample) begin
      if (state_q == PARIDADE) perr <= parity_err(shreg, rx_s2);
      if (state_q == STOP && !rx_s2) ferr <= 1'b1;
    end
  end

  assign word = {perr, ferr, shreg};
  assign pop  = not_empty & aceito;
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

`ifdef RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  // FIFO storage write
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= word;
  end

  // FIFO pointers and occupancy; push with pop leaves the count unchanged
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [WORD_W-1:0] hold;
  logic              hold_vld;

  assign full      = hold_vld;
  assign not_empty = hold_vld;
  assign head      = hold;

  // Holding register contents
  always_ff @(posedge clock) begin
    if (push) hold <= word;
  end

  // Holding register occupancy; a push refills it even while it is popped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    hold_vld <= 1'b0;
    else if (push) hold_vld <= 1'b1;
    else if (pop)  hold_vld <= 1'b0;
  end
`endif

  // Sticky overrun: set when a word is dropped, cleared by any pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    overrun <= 1'b0;
    else if (pop)  overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end

  // Head-of-FIFO outputs, forced to zero while nothing is held
  always_comb begin
    valido        = not_empty;
    dados         = not_empty ? head[DATA_BITS-1:0] : '0;
    erro_quadro   = not_empty & head[DATA_BITS];
    erro_paridade = not_empty & head[DATA_BITS+1];
  end

endmodule
